// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state enum, the digit-adjust constants and DIGITS_FOR().
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] ADJ_ADD = 4'd3;
   localparam logic [3:0] ADJ_MIN = 4'd5;

   // Smallest digit count d with 10^d > 2^width.
   function automatic int DIGITS_FOR(input int width);
      longint unsigned p;
      longint unsigned lim;
      int d;
      lim = 64'(1) << width;
      p   = 64'd1;
      d   = 0;
      while (p <= lim) begin
         p = p * 64'd10;
         d = d + 1;
      end
      return d;
   endfunction

endpackage

// File: rtl/seq_bin_to_bcd_if.sv
// Operand/result handshake bundle for seq_bin_to_bcd.
// master: in_valid/bin/signed_mode/out_ready; slave: in_ready/out_valid/bcd/neg.
interface seq_bin_to_bcd_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);

   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      bin;
   logic                  signed_mode;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd;
   logic                  neg;

   modport master (
      output in_valid, bin, signed_mode, out_ready,
      input  in_ready, out_valid, bcd, neg
   );

   modport slave (
      input  in_valid, bin, signed_mode, out_ready,
      output in_ready, out_valid, bcd, neg
   );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: q = d + 3 when d >= 5, else d.
// Ports: d (4-bit BCD digit in), q (corrected digit out).
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] d,
   output logic [3:0] q
);

   assign q = (d >= ADJ_MIN) ? d + ADJ_ADD : d;

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Sequential shift-add-3 binary-to-BCD converter, WIDTH cycles per operand.
// Ports: clk, rst_n (async, active-low), io (slave side of seq_bin_to_bcd_if).
module seq_bin_to_bcd
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   seq_bin_to_bcd_if.slave   io
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
      $error("seq_bin_to_bcd: WIDTH must be in 4..32");
   end
   if (DIGITS < DIGITS_FOR(WIDTH)) begin : g_bad_digits
      $error("seq_bin_to_bcd: DIGITS too small for WIDTH");
   end

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  mag;
   logic [BW-1:0]     acc;
   logic [BW-1:0]     adj;
   logic [BW-1:0]     acc_nxt;
   logic [CW-1:0]     cnt;
   logic [BW-1:0]     bcd_q;
   logic              neg_pend;
   logic              neg_q;
   logic              rdy;
   logic              vld;
   logic              accept;
   logic              last;
   logic              is_neg;
   logic [WIDTH-1:0]  mag_in;

   // Negating in WIDTH bits gives the same low bits as the WIDTH+1-bit
   // negation, so the most negative input maps to +2^(WIDTH-1).
   assign is_neg = io.signed_mode & io.bin[WIDTH-1];
   assign mag_in = is_neg ? (~io.bin + 1'b1) : io.bin;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .d (acc[4*i +: 4]),
         .q (adj[4*i +: 4])
      );
   end

   assign acc_nxt = (adj << 1) | {{(BW-1){1'b0}}, mag[WIDTH-1]};
   assign last    = (cnt == CW'(WIDTH - 1));
   assign accept  = io.in_valid & rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rdy       = 1'b0;
      vld       = 1'b0;
      unique case (state)
         IDLE: begin
            rdy = 1'b1;
            if (io.in_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            vld = 1'b1;
            if (io.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result registers only load on the final shift, so bcd/neg never
   // expose partial accumulator contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag      <= '0;
         acc      <= '0;
         cnt      <= '0;
         bcd_q    <= '0;
         neg_pend <= 1'b0;
         neg_q    <= 1'b0;
      end else if (accept) begin
         mag      <= mag_in;
         neg_pend <= is_neg;
         acc      <= '0;
         cnt      <= '0;
      end else if (state == SHIFT) begin
         acc <= acc_nxt;
         mag <= mag << 1;
         cnt <= cnt + 1'b1;
         if (last) begin
            bcd_q <= acc_nxt;
            neg_q <= neg_pend;
         end
      end
   end

   assign io.in_ready  = rdy;
   assign io.out_valid = vld;
   assign io.bcd       = bcd_q;
   assign io.neg       = neg_q;

endmodule

// File: doc/seq_bin_to_bcd.md
SEQ_BIN_TO_BCD -- requirements
Module: seq_bin_to_bcd

Interface
REQ-001 SHALL have parameter WIDTH, default 8, binary input width in bits (legal range 4..32).
REQ-002 SHALL have parameter DIGITS, default 3, number of BCD output digits.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; clk and rst_n are named as the codebase does.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand offered.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 bin  input  WIDTH  operand.
REQ-009 signed_mode  input  1  treat bin as two's complement; sampled with bin.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 bcd  output  4*DIGITS  packed BCD magnitude; digit 0 in bits [3:0].
REQ-013 neg  output  1  result negative (signed_mode only).

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Acceptance SHALL occur on an edge with in_valid && in_ready.
REQ-017 On acceptance the block SHALL latch the magnitude of bin and neg, clear the BCD accumulator and the iteration counter, and go IDLE->SHIFT.
REQ-018 Magnitude SHALL be bin when signed_mode=0, or when signed_mode=1 and bin[WIDTH-1]=0.
REQ-019 Otherwise magnitude SHALL be the two's-complement negation computed on WIDTH+1 bits, so -2^(WIDTH-1) yields +2^(WIDTH-1).
REQ-020 neg SHALL be signed_mode && bin[WIDTH-1] at acceptance.
REQ-021 Each SHIFT cycle SHALL first add 3 to every accumulator digit >=5, then shift the whole accumulator left one bit, inserting the magnitude MSB, then shift the magnitude left.
REQ-022 SHIFT SHALL last exactly WIDTH cycles; on the WIDTH-th shift edge the state SHALL become DONE.
REQ-023 out_valid SHALL rise exactly WIDTH cycles after the acceptance edge; latency is independent of the value.
REQ-024 bcd and neg SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 On out_valid && out_ready the state SHALL go DONE->IDLE; the next operand cannot be accepted before the following edge.
REQ-026 in_valid asserted during SHIFT or DONE SHALL be ignored, and no operand SHALL be latched.
REQ-027 bcd SHALL hold the last result in IDLE until the next conversion completes, and SHALL not change visibly during SHIFT.
REQ-028 Elaboration SHALL fail if 10^DIGITS <= 2^WIDTH, i.e. if digits are insufficient.
REQ-029 Unused upper digits SHALL read 0.

Reset
REQ-030 On rst_n=0 the block SHALL asynchronously enter IDLE with in_ready=1 (after reset), out_valid=0, bcd=0, neg=0, and the counter and accumulator at 0.
REQ-031 Reset mid-SHIFT or in DONE SHALL abort the conversion with no output pulse.
REQ-032 Reset release SHALL be synchronised externally; the block requires no post-reset idle cycles.

Structure
REQ-033 A shared package bcd_pkg SHALL hold the state enum, a DIGITS_FOR(width) constant function, and the correction constant 3 / threshold 5.
REQ-034 One combinational sub-module bcd_digit_adj SHALL take a 4-bit digit and return the digit +3 if it is >=5, else the digit unchanged; it is instantiated DIGITS times via generate.
REQ-035 The counter width SHALL be clog2(WIDTH+1).

Verification
REQ-036 WIDTH=8, bin=255, signed_mode=0 -> bcd=12'h255, neg=0, out_valid exactly 8 cycles after acceptance.
REQ-037 WIDTH=8, signed_mode=1, bin=8'h80 -> bcd=12'h128, neg=1; bin=8'hFF -> bcd=12'h001, neg=1; bin=0 -> 12'h000, neg=0.
REQ-038 WIDTH=16, DIGITS=5, bin=65535 -> bcd=20'h65535; bin=10000 -> 20'h10000.
REQ-039 Hold out_ready=0 for 5 cycles after out_valid -> bcd stable and in_ready=0 throughout; a new in_valid pulse is ignored.
REQ-040 Assert rst_n=0 at SHIFT cycle 4 -> out_valid never asserts, outputs=0, in_ready=1 after release; the next conversion of 99 -> 12'h099.
REQ-041 Back-to-back: in_valid held high with out_ready=1 -> one result every WIDTH+2 cycles, all results correct versus the reference model.
